// File: rtl/logic_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_unit_pkg : function encodings and pipeline-depth bounds         |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package logic_unit_pkg;

  localparam logic [2:0] FUN_AND  = 3'b000;
  localparam logic [2:0] FUN_OR   = 3'b001;
  localparam logic [2:0] FUN_NAND = 3'b010;
  localparam logic [2:0] FUN_NOR  = 3'b011;
  localparam logic [2:0] FUN_XOR  = 3'b100;
  localparam logic [2:0] FUN_XNOR = 3'b101;
  localparam logic [2:0] FUN_SHL  = 3'b110;
  localparam logic [2:0] FUN_SHR  = 3'b111;

  localparam int PIPE_STAGES_MIN = 1;
  localparam int PIPE_STAGES_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/logic_pipe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_pipe_stage : one valid/payload register slice of the pipe       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module logic_pipe_stage #(
  parameter int WIDTH = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // load_i is high when this slice is empty or its content moves on this cycle
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/logic_pipe_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_pipe_unit : pipelined logic/shift unit with valid/ready flow    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module logic_pipe_unit
  import logic_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int OUT_WIDTH   = 16,
  parameter int FUN_WIDTH   = 3,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [FUN_WIDTH-1:0]  ALU_FUN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [OUT_WIDTH-1:0]  Logic_OUT,
  output logic                  OUT_ZERO,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);

  localparam int STAGES = (PIPE_STAGES < PIPE_STAGES_MIN) ? PIPE_STAGES_MIN :
                          (PIPE_STAGES > PIPE_STAGES_MAX) ? PIPE_STAGES_MAX :
                          PIPE_STAGES;
  localparam int SH_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PAY_W  = OUT_WIDTH + 1;

  logic [SH_W-1:0]       w_sh;
  logic [DATA_WIDTH-1:0] w_logic;
  logic [OUT_WIDTH-1:0]  w_a_ext;
  logic [OUT_WIDTH-1:0]  w_result;
  logic                  w_zero;
  logic [STAGES-1:0]     w_valid;
  logic [STAGES:0]       w_ready;
  logic [PAY_W-1:0]      w_data [STAGES];

  // Only the low bits of B select the shift distance
  if (DATA_WIDTH > 1) begin : g_sh
    assign w_sh = B[SH_W-1:0];
  end else begin : g_sh_none
    assign w_sh = '0;
  end

  always_comb begin
    w_logic  = '0;
    w_result = '0;
    w_a_ext  = OUT_WIDTH'(A);
    case (ALU_FUN)
      FUN_WIDTH'(FUN_AND):  w_logic = A & B;
      FUN_WIDTH'(FUN_OR):   w_logic = A | B;
      FUN_WIDTH'(FUN_NAND): w_logic = ~(A & B);
      FUN_WIDTH'(FUN_NOR):  w_logic = ~(A | B);
      FUN_WIDTH'(FUN_XOR):  w_logic = A ^ B;
      FUN_WIDTH'(FUN_XNOR): w_logic = ~(A ^ B);
      FUN_WIDTH'(FUN_SHR):  w_logic = A >> w_sh;
      default:              w_logic = '0;
    endcase
    // Left shift works at output width so bits shifted past DATA_WIDTH survive
    if (ALU_FUN == FUN_WIDTH'(FUN_SHL)) begin
      w_result = w_a_ext << w_sh;
    end else begin
      w_result = OUT_WIDTH'(w_logic);
    end
  end

  assign w_zero = (w_result == '0);

  // A stage can take new data if it or any stage downstream has room
  always_comb begin
    w_ready          = '0;
    w_ready[STAGES]  = OUT_READY;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = ~w_valid[k] | w_ready[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_in_valid;
    logic [PAY_W-1:0] w_in_data;

    if (k == 0) begin : g_first
      assign w_in_valid = IN_VALID;
      assign w_in_data  = {w_zero, w_result};
    end else begin : g_next
      assign w_in_valid = w_valid[k-1];
      assign w_in_data  = w_data[k-1];
    end

    logic_pipe_stage #(
      .WIDTH (PAY_W)
    ) u_stage (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .load_i  (w_ready[k]),
      .valid_i (w_in_valid),
      .data_i  (w_in_data),
      .valid_o (w_valid[k]),
      .data_o  (w_data[k])
    );
  end

  assign IN_READY               = w_ready[0];
  assign OUT_VALID              = w_valid[STAGES-1];
  assign {OUT_ZERO, Logic_OUT}  = w_data[STAGES-1];

endmodule
`default_nettype wire
